// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 4-digit common-anode 7-seg driver fed by a packed BCD word.
// Latency: disp/bcd_err update on the load edge; seg/dp/an follow one edge later.
// No backpressure: load is accepted every cycle it is high, last value wins.
module bcd_display_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd,
  input  logic        load,
  input  logic        blank_lz,
  input  logic [3:0]  dp_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        bcd_err
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [15:0]   disp;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;

  logic [3:0]    nib;
  logic          blanked;
  logic          dark;
  logic [6:0]    seg_nx;
  logic          dp_nx;
  logic [3:0]    an_nx;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  function automatic logic has_bad_nibble(input logic [15:0] w);
    return (w[15:12] > 4'd9) || (w[11:8] > 4'd9) ||
           (w[7:4]   > 4'd9) || (w[3:0]  > 4'd9);
  endfunction

  // A digit is blanked only if it and every more-significant digit are zero.
  always_comb begin
    blanked = 1'b0;
    case (idx)
      2'd1:    blanked = blank_lz && (disp[15:4]  == 12'd0);
      2'd2:    blanked = blank_lz && (disp[15:8]  == 8'd0);
      2'd3:    blanked = blank_lz && (disp[15:12] == 4'd0);
      default: blanked = 1'b0;
    endcase
  end

  always_comb begin
    nib    = disp[{idx, 2'b00} +: 4];
    dark   = (cnt < CNT_GUARD) || blanked;
    seg_nx = SEG_OFF;
    dp_nx  = 1'b1;
    an_nx  = 4'b1111;
    if (!dark) begin
      seg_nx = decode(nib);
      dp_nx  = ~dp_en[idx];
      an_nx  = ~(4'b0001 << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp    <= 16'd0;
      cnt     <= '0;
      idx     <= 2'd0;
      bcd_err <= 1'b0;
      seg     <= SEG_OFF;
      dp      <= 1'b1;
      an      <= 4'b1111;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        disp    <= bcd;
        bcd_err <= has_bad_nibble(bcd);
      end
      seg <= seg_nx;
      dp  <= dp_nx;
      an  <= an_nx;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomized + directed bench; a cycle-level reference model feeds a scoreboard
// queue that a negedge monitor drains against the DUT outputs.
module tb_bcd_display_scanner;

  localparam int RD = 8;
  localparam int GD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bcd;
  logic        load;
  logic        blank_lz;
  logic [3:0]  dp_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        bcd_err;

  bcd_display_scanner #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk      (clk),
    .reset    (reset),
    .bcd      (bcd),
    .load     (load),
    .blank_lz (blank_lz),
    .dp_en    (dp_en),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .bcd_err  (bcd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       err;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

  // Model: elapsed cycles since reset release determine digit and phase.
  int  t = 0;
  int  mdisp = 0;
  bit  merr = 0;
  int  md, mph, mnib;
  bit  mblank;
  exp_t me;

  always @(posedge clk) begin
    cycle = cycle + 1;
    if (reset) begin
      t = 0; mdisp = 0; merr = 0;
      me.seg = 7'b1111111; me.dp = 1'b1; me.an = 4'b1111; me.err = 1'b0;
    end else begin
      md     = (t / RD) % 4;
      mph    = t % RD;
      mnib   = (mdisp / (1 << (4 * md))) % 16;
      mblank = blank_lz && (md != 0) && ((mdisp / (1 << (4 * md))) == 0);
      if (mph < GD || mblank) begin
        me.seg = 7'b1111111; me.dp = 1'b1; me.an = 4'b1111;
      end else begin
        me.seg = (mnib < 10) ? segtab[mnib] : 7'b0111111;
        me.dp  = ~dp_en[md];
        me.an  = 4'b1111 ^ 4'(1 << md);
      end
      if (load) begin
        mdisp = int'(bcd);
        merr  = 0;
        for (int k = 0; k < 4; k++)
          if (((mdisp / (1 << (4 * k))) % 16) > 9) merr = 1;
      end
      me.err = merr;
      t = t + 1;
    end
    sbq.push_back(me);
  end

  task automatic chk(input string name, input int act, input int expv);
    checks = checks + 1;
    if (act !== expv) begin
      failures = failures + 1;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("seg", int'(seg), int'(e.seg));
      chk("dp", int'(dp), int'(e.dp));
      chk("an", int'(an), int'(e.an));
      chk("bcd_err", int'(bcd_err), int'(e.err));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] w);
    bcd  = w;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] w;
    for (int k = 0; k < 4; k++) w[4*k +: 4] = 4'($urandom_range(0, 9));
    return w;
  endfunction

  initial begin
    int guard_cnt;
    reset = 1'b1; bcd = 16'h0; load = 1'b0; blank_lz = 1'b0; dp_en = 4'b0000;
    cyc(3);
    reset = 1'b0;
    cyc(40);

    load_word(16'h1234);
    cyc(32);

    blank_lz = 1'b1;
    load_word(16'h0070);
    cyc(32);
    load_word(16'h0000);
    cyc(32);

    load_word(16'h12A4);
    cyc(32);
    load_word(16'h0005);
    cyc(32);

    blank_lz = 1'b0;
    dp_en = 4'b0100;
    load_word(16'h8888);
    cyc(32);

    // Reset mid-scan with digit 2 selected and cnt=5.
    dp_en = 4'b0000;
    load_word(16'h9999);
    guard_cnt = 0;
    while ((t % (4 * RD)) != (2 * RD + 5) && guard_cnt < 64) begin
      cyc(1);
      guard_cnt++;
    end
    chk("reach_idx2_cnt5", guard_cnt < 64 ? 1 : 0, 1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(40);

    for (int i = 0; i < 60; i++) begin
      blank_lz = 1'($urandom_range(0, 1));
      dp_en    = 4'($urandom);
      bcd      = ($urandom_range(0, 3) == 0) ? 16'($urandom) : rand_bcd();
      if ($urandom_range(0, 4) == 0) bcd = bcd & 16'h00FF;
      load     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
      end
      cyc(1);
      load = 1'b0;
      cyc($urandom_range(1, 20));
    end

    cyc(2);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
